imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch from the byte-addressed, little-endian, combinational-read Inst_Memory.
//  Owns the PC register, drives the memory address, and buffers fetched words in a small FIFO.
//  Presents words to decode with a valid/ready handshake, and accepts branch/jump redirects.
//  Flags misaligned or out-of-range fetches instead of issuing them.
// PARAMETERS
//  XLEN        32   address/instruction width
//  RESET_PC    0    PC loaded while reset is low
//  IMEM_BYTES  36   memory size in bytes; legal fetch requires pc+4 <= IMEM_BYTES
//  BUF_DEPTH   2    fetch FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     synchronous, active-low reset (also gates Inst_Memory load)
//  imem_pc         out  32    address to Inst_Memory.PC
//  imem_instr      in   32    Inst_Memory.Instr_Code, same-cycle combinational
//  redirect_valid  in   1     taken branch/jump this cycle
//  redirect_pc     in   32    target PC
//  out_valid       out  1     out_instr/out_pc hold a fetched word
//  out_ready       in   1     decode accepts the word this cycle
//  out_pc          out  32    PC of presented word
//  out_instr       out  32    presented instruction
//  fetch_fault     out  1     sticky: fetch stopped on bad PC
//  fault_pc        out  32    offending PC, valid while fetch_fault=1
// BEHAVIOUR
//  Reset (reset==0 at posedge): pc<=RESET_PC, FIFO empty, state<=WAIT, out_valid=0, fetch_fault=0, fault_pc=0.
//  imem_pc=pc at all times; out_pc/out_instr=FIFO head (0 when empty).
//  States:
//   WAIT : one cycle after reset release, so memory contents settle -> FETCH.
//   FETCH: if FIFO not full and pc legal: push {pc,imem_instr} and pc<=pc+4.
//          If FIFO full: no push, pc holds.
//          If pc illegal (pc[1:0]!=0 or pc+4>IMEM_BYTES): no push, fault_pc<=pc -> DRAIN.
//   DRAIN: no fetch; decode empties FIFO normally; when FIFO empty -> FAULT.
//   FAULT: fetch_fault=1, out_valid=0. Left only via redirect or reset.
//  Latency: first out_valid=1 on the 2nd posedge after reset rises; steady state 1 word/cycle with out_ready=1.
//  Handshake: pop when out_valid&&out_ready. Head stays stable while out_valid&&!out_ready.
//  A push and a pop in the same cycle are both honoured when the FIFO is full, so there is no bubble.
//  Redirect (any state except WAIT):
//   - a handshake in the same cycle still completes;
//   - all FIFO entries are then flushed; pc<=redirect_pc; fetch_fault<=0; state<=FETCH;
//   - no push that cycle; out_valid=0 the next cycle; the target word is valid one cycle after.
//   - a misaligned/out-of-range target enters DRAIN -> FAULT on the next fetch attempt.
//  Redirect during WAIT is ignored.
//  reset low mid-operation overrides everything, including redirect: full reinit.
//  PC arithmetic is XLEN-bit modulo 2^XLEN; overflow is caught by the range check, never wrapped silently.
//  FIFO pointers wrap modulo BUF_DEPTH; an extra count bit distinguishes full from empty.
// STRUCTURE
//  Shared package riscv_fetch_pkg: XLEN, INSTR_BYTES=4, fetch state encoding (WAIT/FETCH/DRAIN/FAULT),
//  {pc,instr} entry struct.
//  Sub-module fetch_fifo: synchronous FIFO, width 64, depth BUF_DEPTH, with flush input.
//  Top level: PC register, FSM, range check.
// TESTING
//  Memory model: 0xfc200002@0, 0xfc000003@4, 0xfc400008@8, out_ready=1.
//   Release reset -> out_valid rises at edge 2, with out_pc 0,4,8 and out_instr matching, one per cycle.
//  Backpressure: out_ready=0 for 5 cycles after the first word -> out_pc stays 0, FIFO fills (2),
//   imem_pc holds at 8; on release, words 0,4,8 follow back-to-back.
//  Redirect: redirect_pc=0x14 while the FIFO holds 2 words and out_ready=1 -> head consumed,
//   rest flushed, one bubble, next out_pc=0x14 and out_instr=0x01400140... (model @0x14).
//  Sequential run to PC 36 -> words up to pc 32 delivered, then fetch_fault=1, fault_pc=0x24, out_valid=0.
//   Redirect to 0 -> fault cleared, word@0 delivered.
//  Misaligned redirect_pc=0x6 -> no word delivered, fetch_fault=1, fault_pc=0x6.
//  Reset low for 1 cycle mid-stream with a redirect pending -> FIFO empty, pc=0, fault cleared;
//   the restart sequence matches the first scenario.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch definitions: widths, fetch FSM encoding, FIFO entry layout and the PC legality check.
package riscv_fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   localparam int ENTRY_W = 2 * XLEN;

   // A fetch is legal when the word is aligned and lies entirely inside memory.
   // The end address is formed one bit wider so a PC near 2^XLEN cannot wrap into range.
   function automatic logic pc_is_legal(input logic [XLEN-1:0] pc,
                                        input logic [XLEN:0]   mem_bytes);
      logic [XLEN:0] end_addr;
      end_addr = {1'b0, pc} + (XLEN+1)'(INSTR_BYTES);
      return (pc[1:0] == 2'b00) && (end_addr <= mem_bytes);
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the memory, decode-handshake, redirect and fault signals around the fetch controller.
interface imem_fetch_ctrl_if;
   import riscv_fetch_pkg::*;

   logic [XLEN-1:0] imem_pc;
   logic [XLEN-1:0] imem_instr;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;
   logic            fetch_fault;
   logic [XLEN-1:0] fault_pc;

   // Fetch controller side.
   modport master (
      output imem_pc,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_pc,
      output out_instr,
      output fetch_fault,
      output fault_pc
   );

   // Environment side: memory, decode and branch unit.
   modport slave (
      input  imem_pc,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_pc,
      input  out_instr,
      input  fetch_fault,
      input  fault_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc,instr} words with a single-cycle flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] entries_q [DEPTH];
   logic [WIDTH-1:0] entries_d [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok  = pop && !empty;
   // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
   assign push_ok = push && (!full || pop_ok);
   assign head_data = empty ? '0 : entries_q[rd_ptr_q[AW-1:0]];

   // Advance pointers on push/pop; flush discards every entry at once.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Write the pushed word into the tail slot.
   always_comb begin
      entries_d = entries_q;
      if (push_ok && !flush) entries_d[wr_ptr_q[AW-1:0]] = push_data;
   end

   // Pointer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage needs no reset: the pointers decide what is visible.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction memory,
// buffers words for decode, follows redirects and stops with a sticky fault on a bad PC.
module imem_fetch_ctrl
   import riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     IMEM_BYTES = 36,
   parameter int              BUF_DEPTH  = 2
) (
   input  logic               clk,
   input  logic               reset,
   imem_fetch_ctrl_if.master  bus
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] fault_pc_q, fault_pc_d;

   logic            pc_legal;
   logic            redirect_take;
   logic            out_valid;
   logic            fetch_fault;
   logic            fifo_pop;
   logic            fifo_push;
   logic            fifo_empty;
   logic            fifo_full;
   logic            fetch_go;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   assign pc_legal      = pc_is_legal(pc_q, (XLEN+1)'(IMEM_BYTES));
   // The one-cycle settle window after reset release ignores redirects.
   assign redirect_take = bus.redirect_valid && (state_q != ST_WAIT);
   assign fifo_pop      = out_valid && bus.out_ready;
   assign fetch_go      = (state_q == ST_FETCH) && !redirect_take && pc_legal &&
                          (!fifo_full || fifo_pop);
   assign fifo_push     = fetch_go;
   assign push_entry    = '{pc: pc_q, instr: bus.imem_instr};

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_take),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head_data (head_entry),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // FSM state register; reset wins over any redirect.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_WAIT;
      else        state_q <= state_d;
   end

   // Next-state logic: a redirect restarts fetching from any state except WAIT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_WAIT:  state_d = ST_FETCH;
         ST_FETCH: begin
            if (redirect_take)  state_d = ST_FETCH;
            else if (!pc_legal) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (redirect_take)   state_d = ST_FETCH;
            else if (fifo_empty) state_d = ST_FAULT;
         end
         ST_FAULT: begin
            if (redirect_take) state_d = ST_FETCH;
         end
         default:  state_d = ST_WAIT;
      endcase
   end

   // FSM outputs: decode sees words only outside FAULT; the fault flag is the FAULT state itself.
   always_comb begin
      out_valid   = !fifo_empty && (state_q != ST_FAULT);
      fetch_fault = (state_q == ST_FAULT);
   end

   // PC and fault address: redirect loads the target, a successful fetch steps one word,
   // and the first illegal PC seen in FETCH is captured for reporting.
   always_comb begin
      pc_d       = pc_q;
      fault_pc_d = fault_pc_q;
      if (redirect_take) begin
         pc_d = bus.redirect_pc;
      end else if (fetch_go) begin
         pc_d = pc_q + XLEN'(INSTR_BYTES);
      end else if ((state_q == ST_FETCH) && !pc_legal) begin
         fault_pc_d = pc_q;
      end
   end

   // PC and fault address registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         fault_pc_q <= '0;
      end else begin
         pc_q       <= pc_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   assign bus.imem_pc     = pc_q;
   assign bus.out_valid   = out_valid;
   assign bus.out_pc      = head_entry.pc;
   assign bus.out_instr   = head_entry.instr;
   assign bus.fetch_fault = fetch_fault;
   assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios followed by a randomized run against a
// stream-level model (expected next delivered PC, expected faulting PC).
module tb_imem_fetch_ctrl;

   localparam int unsigned MEM_BYTES = 36;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   imem_fetch_ctrl_if bus();

   imem_fetch_ctrl #(
      .RESET_PC   (32'h0),
      .IMEM_BYTES (MEM_BYTES),
      .BUF_DEPTH  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory contents, one word per aligned address.
   function automatic logic [31:0] model_word(input logic [31:0] addr);
      case (addr)
         32'd0:   return 32'hfc200002;
         32'd4:   return 32'hfc000003;
         32'd8:   return 32'hfc400008;
         32'd12:  return 32'h00c00093;
         32'd16:  return 32'h00100113;
         32'd20:  return 32'h01400140;
         32'd24:  return 32'h00208193;
         32'd28:  return 32'h00318233;
         32'd32:  return 32'h0000006f;
         default: return 32'hdeadbeef;
      endcase
   endfunction

   assign bus.imem_instr = model_word(bus.imem_pc);

   function automatic bit model_legal(input logic [31:0] pc);
      logic [63:0] ext;
      ext = {32'h0, pc};
      return (ext % 4 == 0) && (ext + 4 <= 64'(MEM_BYTES));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_word(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_pc"},  64'(bus.out_pc), 64'(pc));
      chk({tag, "_ins"}, 64'(bus.out_instr), 64'(instr));
   endtask

   // Hold reset low across two edges, then release; returns at the release negedge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic bad_target(input string tag, input logic [31:0] target);
      int n;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      n = 0;
      while (!bus.fetch_fault && n < 6) begin
         chk({tag, "_novld"}, 64'(bus.out_valid), 64'd0);
         @(negedge clk);
         n++;
      end
      chk({tag, "_fault"}, 64'(bus.fetch_fault), 64'd1);
      chk({tag, "_fpc"},   64'(bus.fault_pc), 64'(target));
      chk({tag, "_vld"},   64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] target;
      bit          prev_rst, rst, rdy, redir, handshake;
      int          stall, fault_wait, n, r;

      reset = 1'b0;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_vld",   64'(bus.out_valid), 64'd0);
      chk("rst_fault", 64'(bus.fetch_fault), 64'd0);
      chk("rst_fpc",   64'(bus.fault_pc), 64'd0);
      chk("rst_ipc",   64'(bus.imem_pc), 64'd0);
      chk("rst_opc",   64'(bus.out_pc), 64'd0);
      chk("rst_oins",  64'(bus.out_instr), 64'd0);

      // Startup latency and streaming
      reset = 1'b1;
      @(negedge clk);
      chk("s1_bubble", 64'(bus.out_valid), 64'd0);
      @(negedge clk); expect_word("s1_w0", 32'h0, 32'hfc200002);
      @(negedge clk); expect_word("s1_w1", 32'h4, 32'hfc000003);
      @(negedge clk); expect_word("s1_w2", 32'h8, 32'hfc400008);

      // Backpressure
      do_reset();
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("s2_bubble", 64'(bus.out_valid), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         expect_word("s2_hold", 32'h0, 32'hfc200002);
      end
      chk("s2_ipc_hold", 64'(bus.imem_pc), 64'd8);
      bus.out_ready = 1'b1;
      @(negedge clk); expect_word("s2_w1", 32'h4, 32'hfc000003);
      @(negedge clk); expect_word("s2_w2", 32'h8, 32'hfc400008);
      @(negedge clk); expect_word("s2_w3", 32'hc, 32'h00c00093);

      // Redirect with two buffered words
      do_reset();
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("s3_ipc_full", 64'(bus.imem_pc), 64'd8);
      expect_word("s3_head", 32'h0, 32'hfc200002);
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h14;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk("s3_bubble", 64'(bus.out_valid), 64'd0);
      chk("s3_ipc", 64'(bus.imem_pc), 64'h14);
      @(negedge clk); expect_word("s3_tgt", 32'h14, 32'h01400140);
      @(negedge clk); expect_word("s3_tgt1", 32'h18, 32'h00208193);

      // Run off the end of memory
      do_reset();
      @(negedge clk);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         expect_word("s4_seq", 32'(4 * k), model_word(32'(4 * k)));
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         chk("s4_drain_vld", 64'(bus.out_valid), 64'd0);
      end while (!bus.fetch_fault && n < 6);
      chk("s4_fault", 64'(bus.fetch_fault), 64'd1);
      chk("s4_fpc",   64'(bus.fault_pc), 64'h24);
      chk("s4_opc",   64'(bus.out_pc), 64'd0);
      repeat (3) @(negedge clk);
      chk("s4_sticky", 64'(bus.fetch_fault), 64'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk("s4_clr", 64'(bus.fetch_fault), 64'd0);
      chk("s4_clr_vld", 64'(bus.out_valid), 64'd0);
      @(negedge clk); expect_word("s4_restart", 32'h0, 32'hfc200002);

      // Bad redirect targets: misaligned and wrapping past 2^32
      bad_target("s5_mis", 32'h6);
      bad_target("s5_ovf", 32'hffff_fffc);

      // Reset mid-stream with a redirect pending, redirect held through WAIT
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      @(negedge clk); expect_word("s6_pre", 32'h0, 32'hfc200002);
      reset = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h14;
      @(negedge clk);
      reset = 1'b1;
      chk("s6_rst_vld",   64'(bus.out_valid), 64'd0);
      chk("s6_rst_fault", 64'(bus.fetch_fault), 64'd0);
      chk("s6_rst_ipc",   64'(bus.imem_pc), 64'd0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk("s6_wait_ign", 64'(bus.imem_pc), 64'd0);
      chk("s6_bubble", 64'(bus.out_valid), 64'd0);
      @(negedge clk); expect_word("s6_w0", 32'h0, 32'hfc200002);
      @(negedge clk); expect_word("s6_w1", 32'h4, 32'hfc000003);
      @(negedge clk); expect_word("s6_w2", 32'h8, 32'hfc400008);

      // Randomized run against the stream model
      exp_pc = 32'h0; prev_rst = 1'b0; stall = 0; fault_wait = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc > 0) begin
            if (prev_rst) begin
               chk("rnd_rst_vld", 64'(bus.out_valid), 64'd0);
               chk("rnd_rst_ff",  64'(bus.fetch_fault), 64'd0);
               chk("rnd_rst_ipc", 64'(bus.imem_pc), 64'd0);
               chk("rnd_rst_fpc", 64'(bus.fault_pc), 64'd0);
            end
            if (bus.fetch_fault) begin
               chk("rnd_fault_pc",    64'(bus.fault_pc), 64'(exp_pc));
               chk("rnd_fault_legal", 64'(model_legal(exp_pc)), 64'd0);
               chk("rnd_fault_vld",   64'(bus.out_valid), 64'd0);
            end
            if (!model_legal(exp_pc) && !bus.fetch_fault && !bus.out_valid) fault_wait++;
            chk("rnd_fault_late", 64'(fault_wait > 4), 64'd0);
            if (model_legal(exp_pc) && !bus.out_valid) stall++;
            else stall = 0;
            chk("rnd_stall", 64'(stall > 4), 64'd0);
         end

         rst   = (cyc == 0) || ($urandom_range(0, 199) == 0);
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 19) == 0);
         r     = int'($urandom_range(0, 19));
         if (r < 14)      target = 32'($urandom_range(0, 8) * 4);
         else if (r < 17) target = 32'($urandom_range(0, 8) * 4 + $urandom_range(1, 3));
         else if (r < 19) target = 32'($urandom_range(9, 15) * 4);
         else             target = 32'hffff_fffc;

         handshake = bus.out_valid && rdy && !rst && (cyc > 0);
         if (handshake) begin
            chk("rnd_pc",  64'(bus.out_pc), 64'(exp_pc));
            chk("rnd_ins", 64'(bus.out_instr), 64'(model_word(exp_pc)));
            exp_pc = exp_pc + 32'd4;
         end
         if (rst) begin
            exp_pc = 32'h0; stall = 0; fault_wait = 0;
         end else if (redir && !prev_rst) begin
            exp_pc = target; stall = 0; fault_wait = 0;
         end

         reset              = !rst;
         bus.out_ready      = rdy;
         bus.redirect_valid = redir;
         bus.redirect_pc    = target;
         prev_rst           = rst;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
